// File: rtl/step_dir_receiver.sv
// step_dir_receiver
// Conditions raw STEP/DIR motion-command pins: two-flop synchronisers,
// per-pin glitch filters, STEP rising-edge strobe, DIR setup-time check and
// a signed, wrapping position counter.
//
// Strobe / counting rule (one place, applies to every output below):
//   A STEP rise is "accepted" on the clock edge where the filtered STEP level
//   is 1, its registered copy is 0, the receiver is armed and enable is 1.
//   On that same edge step_pulse goes high for one cycle, position moves by
//   one in the direction shown by dir_out, and the DIR setup check is applied.
module step_dir_receiver #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned DIR_SETUP  = 8,
  parameter int unsigned POS_W      = 32,
  parameter bit          INVERT_DIR = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             clear_pos,
  input  logic             err_clr,
  output logic             step_pulse,
  output logic             dir_out,
  output logic [POS_W-1:0] position,
  output logic             setup_err
);

  // Filter counter terminal value: FILTER_LEN differing samples move the level.
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  // Setup counter only needs to reach DIR_SETUP, where it saturates.
  localparam int unsigned DS_W = (DIR_SETUP < 2) ? 1 : $clog2(DIR_SETUP + 1);
  localparam logic [DS_W-1:0] DS_MAX = DS_W'(DIR_SETUP);

  // Synchroniser chains (meta = first flop, sync = second flop).
  logic step_meta_q, step_sync_q;
  logic dir_meta_q,  dir_sync_q;

  // Marks when the sync flops hold real pin samples rather than reset values.
  logic [1:0] sync_vld_q;

  // Glitch filters.
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       step_filt_q, step_filt_d;
  logic [7:0] dir_cnt_q, dir_cnt_d;
  logic       dir_filt_q, dir_filt_d;

  // Edge tracking and arming.
  logic step_filt_prev_q;
  logic armed_q, armed_d;

  // Strobe, position, setup check.
  logic             pulse_q, pulse_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DS_W-1:0]  dsetup_q, dsetup_d;
  logic             err_q, err_d;

  logic             dir_level;
  logic             dir_change;
  logic             step_rise;
  logic             step_accept;
  logic             setup_viol;
  logic [POS_W-1:0] pos_delta;

  // Two-flop synchronisers for both pins plus the sample-valid shifter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      dir_meta_q  <= 1'b0;
      dir_sync_q  <= 1'b0;
      sync_vld_q  <= 2'b00;
    end else begin
      step_meta_q <= step_in;
      step_sync_q <= step_meta_q;
      dir_meta_q  <= dir_in;
      dir_sync_q  <= dir_meta_q;
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
    end
  end

  // STEP filter: the level follows sync only after FILTER_LEN differing samples.
  always_comb begin
    step_cnt_d  = step_cnt_q;
    step_filt_d = step_filt_q;
    if (step_sync_q == step_filt_q) begin
      step_cnt_d = 8'd0;
    end else if (step_cnt_q == FILT_LAST) begin
      step_filt_d = step_sync_q;
      step_cnt_d  = 8'd0;
    end else begin
      step_cnt_d = step_cnt_q + 8'd1;
    end
  end

  // DIR filter: same rule as STEP.
  always_comb begin
    dir_cnt_d  = dir_cnt_q;
    dir_filt_d = dir_filt_q;
    if (dir_sync_q == dir_filt_q) begin
      dir_cnt_d = 8'd0;
    end else if (dir_cnt_q == FILT_LAST) begin
      dir_filt_d = dir_sync_q;
      dir_cnt_d  = 8'd0;
    end else begin
      dir_cnt_d = dir_cnt_q + 8'd1;
    end
  end

  // Filter state registers and the delayed filtered STEP used for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_cnt_q       <= 8'd0;
      step_filt_q      <= 1'b0;
      dir_cnt_q        <= 8'd0;
      dir_filt_q       <= 1'b0;
      step_filt_prev_q <= 1'b0;
    end else begin
      step_cnt_q       <= step_cnt_d;
      step_filt_q      <= step_filt_d;
      dir_cnt_q        <= dir_cnt_d;
      dir_filt_q       <= dir_filt_d;
      step_filt_prev_q <= step_filt_q;
    end
  end

  // Edge acceptance, setup counter, strobe, position and sticky error.
  always_comb begin
    dir_level  = dir_filt_q ^ INVERT_DIR;
    dir_change = (dir_filt_d != dir_filt_q);

    // After reset the pin must be seen low (on a real sample) before any
    // rise counts, so a pin held high through reset never strobes.
    armed_d = armed_q | (sync_vld_q[1] & ~step_sync_q);

    step_rise   = step_filt_q & ~step_filt_prev_q & armed_q;
    step_accept = step_rise & enable;

    // Clocks since the last filtered DIR change, saturating at DIR_SETUP.
    dsetup_d = dsetup_q;
    if (dir_change) begin
      dsetup_d = '0;
    end else if (dsetup_q != DS_MAX) begin
      dsetup_d = dsetup_q + 1'b1;
    end

    setup_viol = (DIR_SETUP != 0) && (dsetup_q < DS_MAX);

    // +1 is 0..01, -1 is all ones.
    pos_delta = {{(POS_W-1){~dir_level}}, 1'b1};

    pulse_d = step_accept;

    pos_d = pos_q;
    if (clear_pos) begin
      pos_d = '0;
    end else if (step_accept) begin
      pos_d = pos_q + pos_delta;
    end

    // A new violation wins over a same-cycle clear.
    err_d = err_q;
    if (step_accept && setup_viol) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Registers for arming, setup counter, strobe, position and error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed_q  <= 1'b0;
      dsetup_q <= DS_MAX;
      pulse_q  <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      dsetup_q <= dsetup_d;
      pulse_q  <= pulse_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign step_pulse = pulse_q;
  assign dir_out    = dir_filt_q ^ INVERT_DIR;
  assign position   = pos_q;
  assign setup_err  = err_q;

endmodule
